mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Next-generation multi-cycle control unit for the ARM-subset datapath: main FSM, ALU decoder and PC/immediate/register-source logic in one block.
- Adds what the current decoder lacks:
  - optional memory ready/wait handshake with a timeout fault;
  - iterative-multiplier handshake for MUL/SMUL;
  - compare-only (CMP) instructions that skip register writeback;
  - ARM-correct partial flag write for logical ops.
- Sits between the instruction register and the datapath; drives every datapath enable/mux select.

Parameters:
- MEM_HS, 0, 1 = FETCH/MEMRD/MEMWR wait for MemReady; 0 = memory always single-cycle (MemReady ignored).
- MUL_ITER, 0, 1 = MUL/SMUL go through MULWAIT until MulDone; 0 = single-cycle multiply.
- WAIT_MAX, 16, cycles a memory state may wait before Fault (2..255).
- ALUC_W, 3, ALUControl width (>=3; upper bits zero-filled).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Op  in  2  instruction op field
- Funct  in  6  instruction funct field ([5]=I, [4:1]=cmd, [0]=S/L)
- Rd  in  4  destination register
- MemReady  in  1  memory completes this cycle
- MulDone  in  1  iterative multiplier result valid
- FlagW  out  2  [1]=write NZ, [0]=write CV
- PCS  out  1  PC write from result
- NextPC  out  1  PC+4 write
- RegW  out  1  register file write (raw; conditional logic gates it)
- MemW  out  1  memory write
- IRWrite  out  1  instruction register load
- AdrSrc  out  1  0=PC, 1=result
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=reg, 01=imm, 10=4
- ImmSrc  out  2  equals Op
- RegSrc  out  2  [0]=(Op==10), [1]=(Op==01)
- ALUControl  out  ALUC_W  ALU operation
- MulStart  out  1  one-cycle start pulse to multiplier
- Fault  out  1  sticky memory-timeout flag
- State  out  4  current FSM state (debug)

Behaviour:
- Reset (reset=0, async): State=FETCH, wait counter=0, Fault=0. All combinational outputs follow FETCH decoding.
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, MULWAIT=8, ALUWB=9, BRANCH=10, UNKNOWN=11.
- Per-state outputs (unlisted outputs = 0):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=1 only when the memory is "done" (see done definition below).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWR: AdrSrc=1, MemW=1 (held for all wait cycles).
  - EXECR: ALUSrcB=00, ALUOp.
  - EXECI: ALUSrcB=01, ALUOp.
  - MULWAIT: ALUOp.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch.
- Transitions:
  - FETCH -> DECODE on done.
  - DECODE:
    - Op=01 -> MEMADR;
    - Op=00 with Funct[5]=0 -> EXECR, with Funct[5]=1 -> EXECI;
    - Op=10 -> BRANCH;
    - Op=11 -> UNKNOWN.
  - MEMADR: Funct[0]=1 -> MEMRD, else -> MEMWR.
  - MEMRD -> MEMWB on done. MEMWB -> FETCH.
  - MEMWR -> FETCH on done.
  - EXECR/EXECI:
    - cmd=1010 (CMP) -> FETCH;
    - else MUL_ITER=1 and cmd in {1001,1101} -> MULWAIT, with MulStart=1 for exactly the cycle of entry;
    - else -> ALUWB.
  - MULWAIT -> ALUWB when MulDone=1; MulStart=0 while waiting.
  - ALUWB, BRANCH, UNKNOWN -> FETCH.
- done = (MEM_HS==0) | MemReady.
- Wait counter (FETCH/MEMRD/MEMWR only):
  - increments each not-done cycle; clears on leaving the state.
  - reaching WAIT_MAX sets Fault=1 and forces FETCH; no IRWrite/NextPC/RegW are issued.
  - Fault clears only on reset.
- ALU decode, when ALUOp=1 (cmd -> ALUControl):
  - 0100 ADD -> 000
  - 0010 SUB -> 001
  - 1010 CMP -> 001
  - 0000 AND -> 010
  - 1100 ORR -> 011
  - 0001 EOR -> 100
  - 1101 SMUL -> 110
  - 1001 MUL -> 111
  - other -> 000
- FlagW when ALUOp=1:
  - FlagW[1] = Funct[0], or 1 for CMP.
  - FlagW[0] = FlagW[1] and cmd in {ADD, SUB, CMP}.
  - ALUOp=0 -> ALUControl=0, FlagW=00.
- FlagW is asserted only in EXECR/EXECI, never in MULWAIT.
- PCS = Branch | (Rd==1111 & RegW).
- Async reset mid-wait or mid-multiply: immediately FETCH; MulStart is not reissued.

Test Plan:
- ADD R1 reg (Op=00, Funct=001000): FETCH->DECODE->EXECR->ALUWB->FETCH, 4 cycles; ALUControl=000 in EXECR; RegW=1 only in ALUWB; FlagW=00.
- LDR with MEM_HS=1 (Op=01, Funct=011001), MemReady low 3 cycles in MEMRD: MEMRD held 4 cycles; AdrSrc=1 throughout; MEMWB then RegW=1, ResultSrc=01; Fault=0.
- MEM_HS=1, WAIT_MAX=16, MemReady stuck 0 in FETCH: Fault rises after cycle 16; IRWrite never asserted; State returns to FETCH.
- MUL_ITER=1, MUL (Funct=010010): MulStart is a single pulse on the EXECR->MULWAIT edge; MulDone after 5 cycles -> ALUWB; ALUControl=111; FlagW=00.
- CMP imm (Funct=110101): EXECI->FETCH with no ALUWB; FlagW=11; ALUControl=001. ANDS reg (Funct=000001): FlagW=10.
- reset=0 asserted in MULWAIT: State=0 asynchronously, before the next clock edge. Register write to PC (Rd=1111) in ALUWB: PCS=1.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit: main FSM, ALU decoder and PC/imm/reg-source logic.
// Optional memory handshake with timeout fault and iterative-multiplier wait.
module mc_control_unit #(
    parameter int MEM_HS   = 0,
    parameter int MUL_ITER = 0,
    parameter int WAIT_MAX = 16,
    parameter int ALUC_W   = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        Op,
    input  logic [5:0]        Funct,
    input  logic [3:0]        Rd,
    input  logic              MemReady,
    input  logic              MulDone,
    output logic [1:0]        FlagW,
    output logic              PCS,
    output logic              NextPC,
    output logic              RegW,
    output logic              MemW,
    output logic              IRWrite,
    output logic              AdrSrc,
    output logic [1:0]        ResultSrc,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        ImmSrc,
    output logic [1:0]        RegSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              MulStart,
    output logic              Fault,
    output logic [3:0]        State
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        MULWAIT = 4'd8,
        ALUWB   = 4'd9,
        BRANCH  = 4'd10,
        UNKNOWN = 4'd11
    } state_t;

    state_t     st, nxt;
    logic [7:0] wcnt;
    logic [3:0] cmd;
    logic       done, memst, tmo;
    logic       iscmp, ismul, addsub;
    logic       aluop, branch, fw1;
    logic [2:0] alu3;

    assign cmd    = Funct[4:1];
    assign done   = (MEM_HS == 0) | MemReady;
    assign memst  = (st == FETCH) | (st == MEMRD) | (st == MEMWR);
    assign tmo    = memst & ~done & (wcnt == 8'(WAIT_MAX - 1));
    assign iscmp  = (cmd == 4'b1010);
    assign ismul  = (MUL_ITER != 0) & ((cmd == 4'b1001) | (cmd == 4'b1101));
    assign addsub = (cmd == 4'b0100) | (cmd == 4'b0010) | iscmp;

    always_comb begin
        nxt = FETCH;
        case (st)
            FETCH:   nxt = done ? DECODE : FETCH;
            DECODE: begin
                unique case (1'b1)
                    (Op == 2'b01): nxt = MEMADR;
                    (Op == 2'b00): nxt = Funct[5] ? EXECI : EXECR;
                    (Op == 2'b10): nxt = BRANCH;
                    (Op == 2'b11): nxt = UNKNOWN;
                endcase
            end
            MEMADR:  nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:   nxt = done ? MEMWB : MEMRD;
            MEMWR:   nxt = done ? FETCH : MEMWR;
            EXECR, EXECI: begin
                if (iscmp)      nxt = FETCH;
                else if (ismul) nxt = MULWAIT;
                else            nxt = ALUWB;
            end
            MULWAIT: nxt = MulDone ? ALUWB : MULWAIT;
            default: nxt = FETCH;
        endcase
    end

    // a timeout overrides the normal transition and never issues a write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st       <= FETCH;
            wcnt     <= '0;
            Fault    <= 1'b0;
            MulStart <= 1'b0;
        end else begin
            MulStart <= (nxt == MULWAIT) & (st != MULWAIT) & ~tmo;
            if (tmo) begin
                Fault <= 1'b1;
                st    <= FETCH;
                wcnt  <= '0;
            end else begin
                st   <= nxt;
                wcnt <= (memst & ~done) ? wcnt + 8'd1 : 8'd0;
            end
        end
    end

    always_comb begin
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        aluop     = 1'b0;
        branch    = 1'b0;
        case (st)
            FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = done;
                NextPC    = done;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR:  ALUSrcB = 2'b01;
            MEMRD:   AdrSrc = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR:   aluop = 1'b1;
            EXECI: begin
                ALUSrcB = 2'b01;
                aluop   = 1'b1;
            end
            MULWAIT: aluop = 1'b1;
            ALUWB:   RegW = 1'b1;
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu3 = 3'b000;
        if (aluop) begin
            case (cmd)
                4'b0100: alu3 = 3'b000;
                4'b0010: alu3 = 3'b001;
                4'b1010: alu3 = 3'b001;
                4'b0000: alu3 = 3'b010;
                4'b1100: alu3 = 3'b011;
                4'b0001: alu3 = 3'b100;
                4'b1101: alu3 = 3'b110;
                4'b1001: alu3 = 3'b111;
                default: alu3 = 3'b000;
            endcase
        end
    end

    // logical ops update only NZ; C/V follow only for add/sub/compare
    assign fw1        = Funct[0] | iscmp;
    assign FlagW      = ((st == EXECR) | (st == EXECI)) ? {fw1, fw1 & addsub} : 2'b00;
    assign ALUControl = ALUC_W'(alu3);
    assign PCS        = branch | ((Rd == 4'hF) & RegW);
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == 2'b01, Op == 2'b10};
    assign State      = st;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed and random instructions against
// a path-level reference model of the multi-cycle control sequence.
module tb_mc_control_unit;

    localparam int WMAX = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] Op = 2'b00;
    logic [5:0] Funct = 6'b0;
    logic [3:0] Rd = 4'b0;
    logic       MemReady = 1'b0;
    logic       MulDone = 1'b0;
    logic [1:0] FlagW, ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic       PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ALUSrcA;
    logic       MulStart, Fault;
    logic [2:0] ALUControl;
    logic [3:0] State;
    logic [19:0] obs;

    typedef struct {
        int   st;
        logic mr;
        logic md;
        logic ms;
        logic tmo;
    } step_t;

    step_t path[$];
    int    vecs = 0;
    int    miss = 0;
    logic  exp_fault = 1'b0;

    always #5 clk = ~clk;

    mc_control_unit #(
        .MEM_HS(1), .MUL_ITER(1), .WAIT_MAX(WMAX), .ALUC_W(3)
    ) dut (
        .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Rd(Rd),
        .MemReady(MemReady), .MulDone(MulDone), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .RegSrc(RegSrc), .ALUControl(ALUControl), .MulStart(MulStart),
        .Fault(Fault), .State(State)
    );

    assign obs = {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
                  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [2:0] alu_code(logic [3:0] c);
        if (c == 4'b0100) return 3'd0;
        if (c == 4'b0010 || c == 4'b1010) return 3'd1;
        if (c == 4'b0000) return 3'd2;
        if (c == 4'b1100) return 3'd3;
        if (c == 4'b0001) return 3'd4;
        if (c == 4'b1101) return 3'd6;
        if (c == 4'b1001) return 3'd7;
        return 3'd0;
    endfunction

    function automatic logic [19:0] exp_out(int st, logic [1:0] op,
                                             logic [5:0] f, logic [3:0] rd,
                                             logic mr);
        logic [1:0] fw, rs, sb;
        logic pcs, np, rw, mw, ir, as, sa, br, aop;
        logic [2:0] ac;
        logic [3:0] c;
        fw = 0; rs = 0; sb = 0; pcs = 0; np = 0; rw = 0; mw = 0;
        ir = 0; as = 0; sa = 0; br = 0; aop = 0; ac = 0;
        c = f[4:1];
        case (st)
            0: begin sa = 1; sb = 2; rs = 2; ir = mr; np = mr; end
            1: begin sa = 1; sb = 2; rs = 2; end
            2: sb = 1;
            3: as = 1;
            4: begin rs = 1; rw = 1; end
            5: begin as = 1; mw = 1; end
            6: aop = 1;
            7: begin sb = 1; aop = 1; end
            8: aop = 1;
            9: rw = 1;
            10: begin sb = 1; rs = 2; br = 1; end
            default: ;
        endcase
        if (aop) ac = alu_code(c);
        if (st == 6 || st == 7) begin
            fw[1] = f[0] | (c == 4'b1010);
            fw[0] = fw[1] & (c == 4'b0100 || c == 4'b0010 || c == 4'b1010);
        end
        pcs = br | ((rd == 4'hF) & rw);
        return {fw, pcs, np, rw, mw, ir, as, rs, sa, sb, op,
                op == 2'b01, op == 2'b10, ac};
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        vecs++;
        assert (o === e) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, o, e, $time);
        end
    endtask

    task automatic add(int st, logic mr, logic md, logic ms, logic tm);
        step_t s;
        s.st = st; s.mr = mr; s.md = md; s.ms = ms; s.tmo = tm;
        path.push_back(s);
    endtask

    task automatic build(logic [1:0] op, logic [5:0] f,
                         int wf, int wm, int ml, bit tm);
        logic [3:0] c;
        int ms;
        c = f[4:1];
        path.delete();
        for (int i = 0; i < wf; i++) add(0, 0, rb(), 0, 0);
        add(0, 1, rb(), 0, 0);
        add(1, rb(), rb(), 0, 0);
        case (op)
            2'b01: begin
                add(2, rb(), rb(), 0, 0);
                ms = f[0] ? 3 : 5;
                if (tm) begin
                    for (int i = 0; i < WMAX; i++)
                        add(ms, 0, rb(), 0, i == WMAX - 1);
                end else begin
                    for (int i = 0; i < wm; i++) add(ms, 0, rb(), 0, 0);
                    add(ms, 1, rb(), 0, 0);
                    if (f[0]) add(4, rb(), rb(), 0, 0);
                end
            end
            2'b00: begin
                add(f[5] ? 7 : 6, rb(), rb(), 0, 0);
                if (c != 4'b1010) begin
                    if (c == 4'b1001 || c == 4'b1101) begin
                        for (int i = 0; i < ml; i++) add(8, rb(), 0, i == 0, 0);
                        add(8, rb(), 1, ml == 0, 0);
                    end
                    add(9, rb(), rb(), 0, 0);
                end
            end
            2'b10: add(10, rb(), rb(), 0, 0);
            default: add(11, rb(), rb(), 0, 0);
        endcase
    endtask

    task automatic run(logic [1:0] op, logic [5:0] f, logic [3:0] rd,
                       int wf, int wm, int ml, bit tm);
        build(op, f, wf, wm, ml, tm);
        Op = op; Funct = f; Rd = rd;
        foreach (path[i]) begin
            MemReady = path[i].mr;
            MulDone  = path[i].md;
            @(negedge clk);
            chk("state", State, path[i].st);
            chk("outs", obs, exp_out(path[i].st, op, f, rd, path[i].mr));
            chk("mulstart", MulStart, path[i].ms);
            chk("fault", Fault, exp_fault);
            @(posedge clk); #1;
            if (path[i].tmo) exp_fault = 1'b1;
        end
    endtask

    task automatic rand_batch(int n);
        logic [3:0] cmds [8];
        logic [1:0] op;
        logic [3:0] c, rd;
        cmds = '{4'b0100, 4'b0010, 4'b1010, 4'b0000,
                 4'b1100, 4'b0001, 4'b1101, 4'b1001};
        for (int k = 0; k < n; k++) begin
            op = 2'($urandom_range(0, 3));
            c  = rb() ? cmds[$urandom_range(0, 7)] : 4'($urandom);
            rd = rb() ? 4'hF : 4'($urandom);
            run(op, {rb(), c, rb()}, rd, $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 5), 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #2;
        chk("rst_state", State, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_mulstart", MulStart, 0);
        chk("rst_outs", obs, exp_out(0, Op, Funct, Rd, MemReady));
        #10 reset = 1'b1;
        @(posedge clk); #1;

        run(2'b00, 6'b001000, 4'd1, 0, 0, 0, 0);
        run(2'b01, 6'b011001, 4'd3, 0, 3, 0, 0);
        run(2'b01, 6'b011000, 4'd2, 1, 2, 0, 0);
        run(2'b00, 6'b010010, 4'd4, 0, 0, 4, 0);
        run(2'b00, 6'b110101, 4'd5, 1, 0, 0, 0);
        run(2'b00, 6'b000001, 4'd6, 0, 0, 0, 0);
        run(2'b00, 6'b001000, 4'hF, 0, 0, 0, 0);
        run(2'b00, 6'b011011, 4'd7, 2, 0, 2, 0);
        run(2'b10, 6'b100000, 4'd0, 0, 0, 0, 0);
        run(2'b11, 6'b000000, 4'd0, 0, 0, 0, 0);

        Op = 2'b00; Funct = 6'b001000; Rd = 4'd1; MemReady = 1'b0;
        for (int i = 0; i < WMAX; i++) begin
            @(negedge clk);
            chk("to_state", State, 0);
            chk("to_irwrite", IRWrite, 0);
            chk("to_fault", Fault, 0);
            @(posedge clk); #1;
        end
        exp_fault = 1'b1;
        @(negedge clk);
        chk("to_fault_set", Fault, 1);
        chk("to_state_after", State, 0);
        @(posedge clk); #1;

        rand_batch(30);

        Op = 2'b00; Funct = 6'b010010; Rd = 4'd2;
        MemReady = 1'b1; MulDone = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("mw_state", State, 8);
        chk("mw_mulstart", MulStart, 1);
        #3 reset = 1'b0;
        exp_fault = 1'b0;
        #1;
        chk("arst_state", State, 0);
        chk("arst_mulstart", MulStart, 0);
        chk("arst_fault", Fault, 0);
        @(negedge clk);
        reset = 1'b1;
        MemReady = 1'b0;
        @(posedge clk); #1;
        chk("arst_hold_state", State, 0);
        chk("arst_no_restart", MulStart, 0);

        run(2'b01, 6'b011001, 4'd7, 0, 0, 0, 1);
        run(2'b01, 6'b011000, 4'd8, 0, 0, 0, 1);
        rand_batch(30);

        @(negedge clk);
        chk("end_state", State, 0);
        chk("end_fault", Fault, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
